// File: rtl/ldpc_cn_if.sv
// Check-node processor port bundle: serial VN message input, per-edge CN message output and status.
interface ldpc_cn_if #(
  parameter int unsigned LLRWIDTH = 6
);
  logic                in_valid;
  logic                in_first;
  logic                in_last;
  logic [LLRWIDTH-1:0] vn_msg;
  logic                out_req;
  logic [LLRWIDTH-1:0] cn_msg;
  logic                out_valid;
  logic                out_last;
  logic                bank_ready;
  logic                deg_err;
  logic                ovr_err;

  modport master (
    output in_valid, in_first, in_last, vn_msg, out_req,
    input  cn_msg, out_valid, out_last, bank_ready, deg_err, ovr_err
  );

  modport slave (
    input  in_valid, in_first, in_last, vn_msg, out_req,
    output cn_msg, out_valid, out_last, bank_ready, deg_err, ovr_err
  );
endinterface

// File: rtl/ldpc_cn.sv
// Offset min-sum check node: serial collect of min1/min2/signs, double-buffered into an output
// bank that is read one extrinsic message per request.
module ldpc_cn #(
  parameter int unsigned LLRWIDTH = 6,
  parameter int unsigned MAX_DEG  = 32,
  parameter int unsigned IDXW     = 5,
  parameter int unsigned OFFSET   = 1
) (
  input  logic     clk,
  input  logic     rst,
  ldpc_cn_if.slave bus
);
  localparam int unsigned MW = LLRWIDTH - 1;
  localparam logic [MW-1:0] Off = MW'(OFFSET);

  typedef logic [MW-1:0] mag_t;
  typedef logic [IDXW:0] cnt_t;

  localparam cnt_t MaxCnt = cnt_t'(MAX_DEG);
  localparam cnt_t One    = cnt_t'(1);

  // Collect accumulators
  mag_t             min1_q, min1_d, min2_q, min2_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             sp_q, sp_d;
  logic [MAX_DEG-1:0] sv_q, sv_d;
  cnt_t             cnt_q, cnt_d;
  logic             commit_q, commit_d;
  logic             deg_err_q, deg_err_d;

  // Output bank
  mag_t             b_min1_q, b_min1_d, b_min2_q, b_min2_d;
  logic [IDXW-1:0]  b_idx_q, b_idx_d;
  logic             b_sp_q, b_sp_d;
  logic [MAX_DEG-1:0] b_sv_q, b_sv_d;
  cnt_t             b_deg_q, b_deg_d;
  cnt_t             rp_q, rp_d;
  logic             bank_ready_q, bank_ready_d;
  logic             ovr_err_q, ovr_err_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [LLRWIDTH-1:0] cn_msg_q, cn_msg_d;

  // in_first starts from freshly initialised accumulators regardless of stale state
  mag_t             c_min1, c_min2, msg_mag;
  logic [IDXW-1:0]  c_idx;
  logic             c_sp, msg_sgn;
  logic [MAX_DEG-1:0] c_sv;
  cnt_t             c_cnt;

  always_comb begin
    c_min1  = bus.in_first ? '1 : min1_q;
    c_min2  = bus.in_first ? '1 : min2_q;
    c_idx   = bus.in_first ? '0 : idx_q;
    c_sp    = bus.in_first ? 1'b0 : sp_q;
    c_sv    = bus.in_first ? '0 : sv_q;
    c_cnt   = bus.in_first ? '0 : cnt_q;
    msg_mag = bus.vn_msg[MW-1:0];
    msg_sgn = bus.vn_msg[LLRWIDTH-1];

    min1_d    = min1_q;
    min2_d    = min2_q;
    idx_d     = idx_q;
    sp_d      = sp_q;
    sv_d      = sv_q;
    cnt_d     = cnt_q;
    deg_err_d = deg_err_q;
    commit_d  = bus.in_valid & bus.in_last;

    if (bus.in_valid) begin
      min1_d = c_min1;
      min2_d = c_min2;
      idx_d  = c_idx;
      sp_d   = c_sp;
      sv_d   = c_sv;
      cnt_d  = c_cnt;
      if (c_cnt == MaxCnt) begin
        deg_err_d = 1'b1;
      end else begin
        sv_d[c_cnt[IDXW-1:0]] = msg_sgn;
        sp_d = c_sp ^ msg_sgn;
        if (msg_mag < c_min1) begin
          min2_d = c_min1;
          min1_d = msg_mag;
          idx_d  = c_cnt[IDXW-1:0];
        end else if (msg_mag < c_min2) begin
          min2_d = msg_mag;
        end
        cnt_d = c_cnt + One;
      end
    end
  end

  logic serve, at_end, out_sgn;
  mag_t sel_mag, out_mag;

  always_comb begin
    serve   = bus.out_req & bank_ready_q;
    at_end  = (rp_q == b_deg_q - One);
    sel_mag = (rp_q[IDXW-1:0] == b_idx_q) ? b_min2_q : b_min1_q;
    out_mag = (sel_mag > Off) ? sel_mag - Off : '0;
    out_sgn = b_sp_q ^ b_sv_q[rp_q[IDXW-1:0]];

    b_min1_d     = b_min1_q;
    b_min2_d     = b_min2_q;
    b_idx_d      = b_idx_q;
    b_sp_d       = b_sp_q;
    b_sv_d       = b_sv_q;
    b_deg_d      = b_deg_q;
    rp_d         = rp_q;
    bank_ready_d = bank_ready_q;
    ovr_err_d    = ovr_err_q;
    out_valid_d  = serve;
    out_last_d   = serve & at_end;
    cn_msg_d     = serve ? {out_sgn, out_mag} : '0;

    if (serve) begin
      rp_d = rp_q + One;
      if (at_end) bank_ready_d = 1'b0;
    end

    // A same-cycle request is served from the old bank; the commit then replaces it.
    if (commit_q) begin
      b_min1_d     = min1_q;
      b_min2_d     = min2_q;
      b_idx_d      = idx_q;
      b_sp_d       = sp_q;
      b_sv_d       = sv_q;
      b_deg_d      = cnt_q;
      rp_d         = '0;
      bank_ready_d = 1'b1;
      if (bank_ready_q && !(serve && at_end)) ovr_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min1_q       <= '1;
      min2_q       <= '1;
      idx_q        <= '0;
      sp_q         <= 1'b0;
      sv_q         <= '0;
      cnt_q        <= '0;
      commit_q     <= 1'b0;
      deg_err_q    <= 1'b0;
      b_min1_q     <= '0;
      b_min2_q     <= '0;
      b_idx_q      <= '0;
      b_sp_q       <= 1'b0;
      b_sv_q       <= '0;
      b_deg_q      <= '0;
      rp_q         <= '0;
      bank_ready_q <= 1'b0;
      ovr_err_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      cn_msg_q     <= '0;
    end else begin
      min1_q       <= min1_d;
      min2_q       <= min2_d;
      idx_q        <= idx_d;
      sp_q         <= sp_d;
      sv_q         <= sv_d;
      cnt_q        <= cnt_d;
      commit_q     <= commit_d;
      deg_err_q    <= deg_err_d;
      b_min1_q     <= b_min1_d;
      b_min2_q     <= b_min2_d;
      b_idx_q      <= b_idx_d;
      b_sp_q       <= b_sp_d;
      b_sv_q       <= b_sv_d;
      b_deg_q      <= b_deg_d;
      rp_q         <= rp_d;
      bank_ready_q <= bank_ready_d;
      ovr_err_q    <= ovr_err_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      cn_msg_q     <= cn_msg_d;
    end
  end

  assign bus.cn_msg     = cn_msg_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_last   = out_last_q;
  assign bus.bank_ready = bank_ready_q;
  assign bus.deg_err    = deg_err_q;
  assign bus.ovr_err    = ovr_err_q;
endmodule

// File: tb/tb_ldpc_cn.sv
// Bench for ldpc_cn: directed vector table, overlap/overflow/reset sequences and random checks
// against an exclude-self min/xor reference model.
module tb_ldpc_cn;
  localparam int LW   = 6;
  localparam int MW   = 5;
  localparam int MAXD = 32;
  localparam int IDXW = 5;
  localparam int OFF  = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ldpc_cn_if #(.LLRWIDTH(LW)) bus ();

  ldpc_cn #(
    .LLRWIDTH(LW),
    .MAX_DEG (MAXD),
    .IDXW    (IDXW),
    .OFFSET  (OFF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int            deg;
    logic [LW-1:0] msg[4];
    logic [LW-1:0] exp[4];
  } vec_t;

  int            errors = 0;
  int            checks = 0;
  logic [LW-1:0] cur[$];
  logic [LW-1:0] expv[$];
  logic [LW-1:0] exp_a[$];
  logic [LW-1:0] bmsg[3];
  vec_t          tbl[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Each edge gets the xor of the other signs and the smallest other magnitude, minus offset.
  function automatic void build_exp();
    logic s;
    int   m;
    expv.delete();
    for (int j = 0; j < cur.size(); j++) begin
      s = 1'b0;
      m = (1 << MW) - 1;
      for (int i = 0; i < cur.size(); i++) begin
        if (i != j) begin
          s ^= cur[i][LW-1];
          if (int'(cur[i][MW-1:0]) < m) m = int'(cur[i][MW-1:0]);
        end
      end
      m = (m > OFF) ? m - OFF : 0;
      expv.push_back({s, MW'(m)});
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic f, input logic l, input logic [LW-1:0] m);
    bus.in_valid = v;
    bus.in_first = f;
    bus.in_last  = l;
    bus.vn_msg   = m;
  endtask

  task automatic load(input logic first_flag);
    for (int i = 0; i < cur.size(); i++) begin
      set_in(1'b1, first_flag && (i == 0), i == cur.size() - 1, cur[i]);
      step();
    end
    set_in(1'b0, 1'b0, 1'b0, '0);
    step();
    chk("bank_ready after commit", bus.bank_ready, 1);
  endtask

  task automatic read_all(input string name, input bit gaps);
    int n      = cur.size();
    int got    = 0;
    int issued = 0;
    for (int c = 0; c < 4 * n + 20 && got < n; c++) begin
      bus.out_req = (issued < n) && (!gaps || ($urandom_range(3) != 0));
      if (bus.out_req) issued++;
      step();
      if (bus.out_valid) begin
        chk({name, " cn_msg"}, bus.cn_msg, expv[got]);
        chk({name, " out_last"}, bus.out_last, got == n - 1);
        got++;
      end
    end
    bus.out_req = 1'b0;
    chk({name, " edges received"}, got, n);
    step();
    chk({name, " bank_ready fell"}, bus.bank_ready, 0);
  endtask

  task automatic chk_zero(input string name);
    chk({name, " outputs"}, {bus.cn_msg, bus.out_valid, bus.out_last, bus.bank_ready,
                              bus.deg_err, bus.ovr_err}, 0);
  endtask

  task automatic chk_no_service(input string name);
    bus.out_req = 1'b1;
    step();
    chk({name, " no out_valid"}, bus.out_valid, 0);
    step();
    chk({name, " no out_valid 2"}, bus.out_valid, 0);
    bus.out_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    tbl[0].deg = 4;
    tbl[0].msg = '{6'h05, 6'h23, 6'h07, 6'h23};
    tbl[0].exp = '{6'h02, 6'h22, 6'h02, 6'h22};
    tbl[1].deg = 1;
    tbl[1].msg = '{6'h29, 6'h00, 6'h00, 6'h00};
    tbl[1].exp = '{6'h1E, 6'h00, 6'h00, 6'h00};
    tbl[2].deg = 3;
    tbl[2].msg = '{6'h00, 6'h04, 6'h26, 6'h00};
    tbl[2].exp = '{6'h23, 6'h20, 6'h00, 6'h00};
    bmsg = '{6'h02, 6'h28, 6'h01};

    set_in(1'b0, 1'b0, 1'b0, '0);
    bus.out_req = 1'b0;
    step();
    step();
    chk_zero("reset");
    rst = 1'b0;
    step();
    chk_no_service("empty bank");

    for (int t = 0; t < 3; t++) begin
      cur.delete();
      expv.delete();
      for (int i = 0; i < tbl[t].deg; i++) begin
        cur.push_back(tbl[t].msg[i]);
        expv.push_back(tbl[t].exp[i]);
      end
      load(1'b1);
      read_all($sformatf("table%0d", t), 1'b0);
    end

    // B collected while A is read; B's in_last lands two cycles after A's out_last
    cur = '{6'h05, 6'h23, 6'h07, 6'h23};
    build_exp();
    exp_a = expv;
    load(1'b1);
    got = 0;
    for (int c = 0; c < 10; c++) begin
      bus.out_req = (c < 4);
      if (c == 2 || c == 4 || c == 6) set_in(1'b1, c == 2, c == 6, bmsg[(c - 2) / 2]);
      else set_in(1'b0, 1'b0, 1'b0, '0);
      step();
      if (c == 5) chk("ovl1 bank_ready gap", bus.bank_ready, 0);
      if (bus.out_valid && got < 4) begin
        chk("ovl1 A cn_msg", bus.cn_msg, exp_a[got]);
        chk("ovl1 A out_last", bus.out_last, got == 3);
        got++;
      end
    end
    set_in(1'b0, 1'b0, 1'b0, '0);
    bus.out_req = 1'b0;
    chk("ovl1 A count", got, 4);
    chk("ovl1 ovr_err", bus.ovr_err, 0);
    chk("ovl1 B bank_ready", bus.bank_ready, 1);
    cur = '{bmsg[0], bmsg[1], bmsg[2]};
    build_exp();
    read_all("ovl1 B", 1'b0);

    for (int t = 0; t < 20; t++) begin
      int n = $urandom_range(MAXD, 1);
      cur.delete();
      for (int i = 0; i < n; i++) begin
        logic [MW-1:0] m;
        m = (t % 2 == 1) ? MW'($urandom_range(3, 0)) : MW'($urandom_range(31, 0));
        cur.push_back({1'($urandom_range(1, 0)), m});
      end
      build_exp();
      load(1'b1);
      read_all($sformatf("rand%0d", t), 1'b1);
    end
    chk("rand deg_err", bus.deg_err, 0);
    chk("rand ovr_err", bus.ovr_err, 0);

    // 33 consecutive messages: last flag on the 32nd, the 33rd overflows
    cur.delete();
    for (int i = 0; i < MAXD; i++) cur.push_back(LW'($urandom_range(63, 0) | 1));
    build_exp();
    for (int i = 0; i < MAXD; i++) begin
      set_in(1'b1, i == 0, i == MAXD - 1, cur[i]);
      step();
    end
    chk("ovf deg_err after 32", bus.deg_err, 0);
    set_in(1'b1, 1'b0, 1'b0, 6'h00);
    step();
    set_in(1'b0, 1'b0, 1'b0, '0);
    chk("ovf deg_err after 33", bus.deg_err, 1);
    chk("ovf bank_ready", bus.bank_ready, 1);
    read_all("ovf", 1'b0);

    // B finishes before A's second read
    cur = '{6'h05, 6'h23, 6'h07, 6'h23};
    build_exp();
    exp_a = expv;
    load(1'b1);
    for (int c = 0; c < 4; c++) begin
      bus.out_req = (c == 0);
      if (c < 3) set_in(1'b1, c == 0, c == 2, bmsg[c]);
      else set_in(1'b0, 1'b0, 1'b0, '0);
      step();
      if (c == 0) begin
        chk("ovl2 A valid", bus.out_valid, 1);
        chk("ovl2 A cn_msg", bus.cn_msg, exp_a[0]);
      end
    end
    bus.out_req = 1'b0;
    chk("ovl2 ovr_err", bus.ovr_err, 1);
    chk("ovl2 bank_ready", bus.bank_ready, 1);
    cur = '{bmsg[0], bmsg[1], bmsg[2]};
    build_exp();
    read_all("ovl2 B", 1'b0);

    // Reset mid-collect, then a check sent without in_first must start from fresh state
    set_in(1'b1, 1'b1, 1'b0, 6'h0A);
    step();
    set_in(1'b1, 1'b0, 1'b0, 6'h21);
    step();
    set_in(1'b0, 1'b0, 1'b0, '0);
    rst = 1'b1;
    #1;
    chk_zero("rst mid-collect");
    step();
    rst = 1'b0;
    chk_no_service("rst mid-collect");
    cur = '{6'h29};
    build_exp();
    load(1'b0);
    read_all("fresh deg1", 1'b0);

    cur = '{6'h05, 6'h23, 6'h07, 6'h23};
    build_exp();
    load(1'b1);
    bus.out_req = 1'b1;
    step();
    step();
    bus.out_req = 1'b0;
    rst = 1'b1;
    #1;
    chk_zero("rst mid-output");
    step();
    rst = 1'b0;
    chk_no_service("rst mid-output");
    cur = '{6'h00, 6'h04, 6'h26};
    build_exp();
    load(1'b1);
    read_all("post reset", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
